// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared types and constants for the sequence controller.
//   step_e  - control step (FETCH, S1, S2, S3), encoded as seen on the step port
//   class_e - instruction class field
//   kind_e  - execution kind produced by seq_ctrl_decode
//   Op*     - class-00 opcode values; AluAdd/AluSub - ALUcont codes for ADDI/SUBI
package seq_ctrl_pkg;

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StS1    = 2'd1,
      StS2    = 2'd2,
      StS3    = 2'd3
   } step_e;

   typedef enum logic [1:0] {
      ClsReg  = 2'b00,
      ClsRsvd = 2'b01,
      ClsAddi = 2'b10,
      ClsSubi = 2'b11
   } class_e;

   typedef enum logic [2:0] {
      KindLoad,
      KindCopy,
      KindUnary,
      KindAlu,
      KindImm,
      KindIllegal
   } kind_e;

   localparam logic [3:0] OpLoad = 4'b0000;
   localparam logic [3:0] OpCopy = 4'b0001;
   localparam logic [3:0] OpAdd  = 4'b0010;
   localparam logic [3:0] OpSub  = 4'b0011;
   localparam logic [3:0] OpInv  = 4'b0100;
   localparam logic [3:0] OpFlp  = 4'b0101;
   localparam logic [3:0] OpAnd  = 4'b0110;
   localparam logic [3:0] OpOr   = 4'b0111;

   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluSub = 4'b0011;

endpackage

// File: rtl/seq_ctrl_decode.sv
// seq_ctrl_decode: combinational classification of the latched instruction.
//   cls  in  2  instruction class field
//   op   in  4  opcode field
//   kind out    execution kind (LOAD/COPY/UNARY/ALU/IMM/ILLEGAL)
// Macro SEQ_CONTROLLER_ILLEGAL_TRAP_EN: undefined encodings decode as ILLEGAL;
// otherwise they run as a three-step register ALU operation.
module seq_ctrl_decode
   import seq_ctrl_pkg::*;
(
   input  class_e      cls,
   input  logic [3:0]  op,
   output kind_e       kind
);

`ifdef SEQ_CONTROLLER_ILLEGAL_TRAP_EN
   localparam kind_e KindUndef = KindIllegal;
`else
   localparam kind_e KindUndef = KindAlu;
`endif

   always_comb begin
      kind = KindUndef;
      unique case (cls)
         ClsReg: begin
            case (op)
               OpLoad:                     kind = KindLoad;
               OpCopy:                     kind = KindCopy;
               OpInv, OpFlp:               kind = KindUnary;
               OpAdd, OpSub, OpAnd, OpOr:  kind = KindAlu;
               default:                    kind = KindUndef;
            endcase
         end
         ClsRsvd:          kind = KindUndef;
         ClsAddi, ClsSubi: kind = KindImm;
      endcase
   end

endmodule

// File: rtl/seq_controller.sv
// seq_controller: multi-step instruction sequencer for a simple register datapath.
// Ports:
//   clk, reset (async, active-high)
//   run, hold, instr_valid, instr[INSTRW-1:0]   fetch/stall control and instruction
//   instr_ready, IRin, Ext, ENW, ENR, Ain, Gin, Gout, imm_sel   datapath strobes
//   Rin, Rout [RW-1:0], ALUcont[3:0], IMM[IMMW-1:0]             selects / function / immediate
//   done (last-step pulse), step[1:0] (current step)
//   illegal (only with SEQ_CONTROLLER_ILLEGAL_TRAP_EN) sticky illegal-instruction flag
// Instruction fields, MSB first: [class 2 | rx RW | ry RW | op 4].
module seq_controller
   import seq_ctrl_pkg::*;
#(
   parameter  int unsigned NREG   = 4,
   localparam int unsigned RW     = $clog2(NREG),
   localparam int unsigned IMMW   = RW + 4,
   localparam int unsigned INSTRW = 2 + 2 * RW + 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              hold,
   input  logic              instr_valid,
   input  logic [INSTRW-1:0] instr,
   output logic              instr_ready,
   output logic              IRin,
   output logic              Ext,
   output logic              ENW,
   output logic              ENR,
   output logic              Ain,
   output logic              Gin,
   output logic              Gout,
   output logic              imm_sel,
   output logic [RW-1:0]     Rin,
   output logic [RW-1:0]     Rout,
   output logic [3:0]        ALUcont,
   output logic [IMMW-1:0]   IMM,
   output logic              done,
   output logic [1:0]        step
`ifdef SEQ_CONTROLLER_ILLEGAL_TRAP_EN
   ,
   output logic              illegal
`endif
);

   step_e             step_q, step_d;
   logic [INSTRW-1:0] ir_q, ir_d;

   class_e        cls;
   logic [RW-1:0] rx, ry;
   logic [3:0]    op;
   logic [3:0]    alu_fn;
   kind_e         kind;

   assign cls = class_e'(ir_q[INSTRW-1 -: 2]);
   assign rx  = ir_q[2*RW+3 -: RW];
   assign ry  = ir_q[RW+3 -: RW];
   assign op  = ir_q[3:0];

   // Immediate forms reuse the ADD/SUB ALU codes; register forms pass op through.
   assign alu_fn = (kind == KindImm) ? ((cls == ClsSubi) ? AluSub : AluAdd) : op;

   seq_ctrl_decode u_decode (
      .cls  (cls),
      .op   (op),
      .kind (kind)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_q <= StFetch;
         ir_q   <= '0;
      end else begin
         step_q <= step_d;
         ir_q   <= ir_d;
      end
   end

   always_comb begin
      step_d      = step_q;
      ir_d        = ir_q;
      instr_ready = 1'b0;
      IRin        = 1'b0;
      Ext         = 1'b0;
      ENW         = 1'b0;
      ENR         = 1'b0;
      Ain         = 1'b0;
      Gin         = 1'b0;
      Gout        = 1'b0;
      imm_sel     = 1'b0;
      Rin         = '0;
      Rout        = '0;
      ALUcont     = '0;
      IMM         = '0;
      done        = 1'b0;

      unique case (step_q)
         StFetch: begin
            instr_ready = 1'b1;
            Ext         = 1'b1;
            IRin        = instr_valid & run;
            if (instr_valid && run) begin
               ir_d   = instr;
               step_d = StS1;
            end
         end
         StS1: begin
            step_d = StS2;
            case (kind)
               KindLoad: begin
                  Ext    = 1'b1;
                  ENW    = 1'b1;
                  Rin    = rx;
                  done   = 1'b1;
                  step_d = StFetch;
               end
               KindCopy: begin
                  ENR    = 1'b1;
                  Rout   = ry;
                  ENW    = 1'b1;
                  Rin    = rx;
                  done   = 1'b1;
                  step_d = StFetch;
               end
               KindUnary: begin
                  ENR     = 1'b1;
                  Rout    = ry;
                  Gin     = 1'b1;
                  ALUcont = op;
               end
               KindImm: begin
                  imm_sel = 1'b1;
                  IMM     = ir_q[IMMW-1:0];
                  Ain     = 1'b1;
               end
               KindIllegal: begin
                  done   = 1'b1;
                  step_d = StFetch;
               end
               default: begin
                  ENR  = 1'b1;
                  Rout = ry;
                  Ain  = 1'b1;
               end
            endcase
         end
         StS2: begin
            if (kind == KindUnary) begin
               Gout   = 1'b1;
               ENW    = 1'b1;
               Rin    = rx;
               done   = 1'b1;
               step_d = StFetch;
            end else begin
               ENR     = 1'b1;
               Rout    = rx;
               Gin     = 1'b1;
               ALUcont = alu_fn;
               step_d  = StS3;
            end
         end
         StS3: begin
            Gout   = 1'b1;
            ENW    = 1'b1;
            Rin    = rx;
            done   = 1'b1;
            step_d = StFetch;
         end
      endcase

      // A held execution step keeps its selects visible but commits nothing.
      if (step_q != StFetch && hold) begin
         step_d = step_q;
         ENW    = 1'b0;
         Gin    = 1'b0;
         Ain    = 1'b0;
         IRin   = 1'b0;
         done   = 1'b0;
      end
   end

   assign step = step_q;

`ifdef SEQ_CONTROLLER_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   assign illegal_d = illegal_q | (step_q == StS1 && kind == KindIllegal && !hold);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) illegal_q <= 1'b0;
      else       illegal_q <= illegal_d;
   end

   assign illegal = illegal_q;
`endif

endmodule
